motor_limit_tracker: RTL and testbench

MOTOR_LIMIT_TRACKER -- requirements
Module: motor_limit_tracker

---
 rtl/door_ctrl_pkg.sv | 22 ++
 rtl/tick_prescaler.sv | 33 +++
 rtl/motor_limit_tracker.sv | 76 +++++++
 tb/tb_motor_limit_tracker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/door_ctrl_pkg.sv
// Shared door-controller types: FSM state encoding and default motor geometry.
// Latency: n/a (package only).
// Backpressure: n/a.
package door_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam int POS_W_DEF    = 8;
    localparam int POS_MAX_DEF  = 200;
    localparam int TICK_DIV_DEF = 4;

    // A divide-by-1 prescaler still needs a one-bit counter to stay legal.
    function automatic int cnt_width(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides motor-drive cycles down to position steps; tick on the TICK_DIV-th enabled cycle.
// Latency: tick is combinational from the registered count.
// Backpressure: none; clr or !en restarts the count.
module tick_prescaler
    import door_ctrl_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = cnt_width(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (clr || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/motor_limit_tracker.sv
// Tracks door position from motor commands; flags limits and sticky conflicting-command fault.
// Latency: Pos steps TICK_DIV cycles after a move starts; limit flags decode Pos with no delay.
// Backpressure: none; FAULT absorbs all commands until reset.
module motor_limit_tracker
    import door_ctrl_pkg::*;
#(
    parameter int POS_W    = POS_W_DEF,
    parameter int POS_MAX  = POS_MAX_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UP_M,
    input  logic             Dn_M,
    output logic             Up_Max,
    output logic             Dn_Max,
    output logic [POS_W-1:0] Pos,
    output logic             Fault
);

    localparam logic [POS_W-1:0] TOP = POS_W'(POS_MAX);

    state_t state;
    state_t state_nxt;
    logic   moving;
    logic   chg;
    logic   tick;

    always_comb begin
        state_nxt = state;
        if (state != FAULT) begin
            case ({UP_M, Dn_M})
                2'b11:   state_nxt = FAULT;
                2'b10:   state_nxt = MOVE_UP;
                2'b01:   state_nxt = MOVE_DN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign moving = (state == MOVE_UP) || (state == MOVE_DN);
    // A state change (including reversal) restarts the step count and suppresses the step.
    assign chg    = (state_nxt != state);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .en   (moving),
        .clr  (chg),
        .tick (tick)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            Pos   <= '0;
            Fault <= 1'b0;
        end else begin
            state <= state_nxt;
            Fault <= (state_nxt == FAULT);
            if (tick) begin
                if (state == MOVE_UP && Pos != TOP) begin
                    Pos <= Pos + POS_W'(1);
                end else if (state == MOVE_DN && Pos != '0) begin
                    Pos <= Pos - POS_W'(1);
                end
            end
        end
    end

    assign Up_Max = (Pos == TOP);
    assign Dn_Max = (Pos == '0);

endmodule

// File: tb/tb_motor_limit_tracker.sv
// Bench for motor_limit_tracker: vector table, hand corner sequences, randomized run vs model.
module tb_motor_limit_tracker;

    localparam int PW = 8;
    localparam int PM = 10;
    localparam int TD = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          UP_M = 1'b0;
    logic          Dn_M = 1'b0;
    logic          Up_Max, Dn_Max, Fault;
    logic [PW-1:0] Pos;

    logic          up1 = 1'b0;
    logic          dn1 = 1'b0;
    logic          umax1, dmax1, flt1;
    logic [PW-1:0] pos1;

    int total = 0;
    int bad   = 0;

    int m_pos, m_run, m_dir;
    bit m_flt;

    always #5 CLK = ~CLK;

    motor_limit_tracker #(.POS_W(PW), .POS_MAX(PM), .TICK_DIV(TD)) dut (
        .CLK(CLK), .RST(RST), .UP_M(UP_M), .Dn_M(Dn_M),
        .Up_Max(Up_Max), .Dn_Max(Dn_Max), .Pos(Pos), .Fault(Fault)
    );

    motor_limit_tracker #(.POS_W(PW), .POS_MAX(3), .TICK_DIV(1)) dut1 (
        .CLK(CLK), .RST(RST), .UP_M(up1), .Dn_M(dn1),
        .Up_Max(umax1), .Dn_Max(dmax1), .Pos(pos1), .Fault(flt1)
    );

    typedef struct {
        bit up;
        bit dn;
        int n;
        int pos;
        bit umax;
        bit dmax;
        bit flt;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_out(input string nm, input int p, input bit um, input bit dm, input bit f);
        chk({nm, ".pos"}, int'(Pos), p);
        chk({nm, ".up_max"}, int'(Up_Max), int'(um));
        chk({nm, ".dn_max"}, int'(Dn_Max), int'(dm));
        chk({nm, ".fault"}, int'(Fault), int'(f));
    endtask

    // Model: position advances once per TICK_DIV consecutive cycles of unchanged drive.
    function automatic void model_reset();
        m_pos = 0; m_run = 0; m_dir = 0; m_flt = 0;
    endfunction

    function automatic void model_step(input bit u, input bit d);
        int nd;
        if (m_flt) return;
        if (u && d) begin
            m_flt = 1;
            return;
        end
        nd = u ? 1 : (d ? -1 : 0);
        if (nd != 0 && nd == m_dir) begin
            m_run++;
            if (m_run % TD == 0) begin
                m_pos = m_pos + m_dir;
                if (m_pos > PM) m_pos = PM;
                if (m_pos < 0)  m_pos = 0;
            end
        end else begin
            m_dir = nd;
            m_run = 0;
        end
    endfunction

    task automatic step(input bit u, input bit d);
        UP_M = u;
        Dn_M = d;
        @(posedge CLK);
        #1;
        model_step(u, d);
    endtask

    task automatic do_reset();
        UP_M = 1'b0;
        Dn_M = 1'b0;
        RST  = 1'b0;
        @(posedge CLK);
        #1;
        RST  = 1'b1;
        model_reset();
    endtask

    initial begin
        int hold;
        bit cu, cd;

        tbl[0]  = '{0, 0,  3,  0, 0, 1, 0};
        tbl[1]  = '{1, 0,  5,  1, 0, 0, 0};
        tbl[2]  = '{1, 0, 36, 10, 1, 0, 0};
        tbl[3]  = '{1, 0, 20, 10, 1, 0, 0};
        tbl[4]  = '{0, 0,  2, 10, 1, 0, 0};
        tbl[5]  = '{0, 1,  5,  9, 0, 0, 0};
        tbl[6]  = '{0, 1,  3,  9, 0, 0, 0};
        tbl[7]  = '{1, 0,  1,  9, 0, 0, 0};
        tbl[8]  = '{1, 0,  4, 10, 1, 0, 0};
        tbl[9]  = '{0, 1, 41,  0, 0, 1, 0};
        tbl[10] = '{0, 1, 10,  0, 0, 1, 0};

        model_reset();
        #2;
        check_out("async_reset", 0, 0, 1, 0);
        do_reset();
        check_out("reset", 0, 0, 1, 0);

        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < tbl[i].n; c++) step(tbl[i].up, tbl[i].dn);
            check_out($sformatf("vec%0d", i), tbl[i].pos, tbl[i].umax, tbl[i].dmax, tbl[i].flt);
        end

        // Reversal: no step on the reversal edge, next step a full period later.
        do_reset();
        for (int c = 0; c < 6; c++) step(1, 0);
        check_out("rev_pre", 1, 0, 0, 0);
        step(0, 1);
        check_out("rev_edge", 1, 0, 0, 0);
        for (int c = 0; c < 3; c++) step(0, 1);
        check_out("rev_early", 1, 0, 0, 0);
        step(0, 1);
        check_out("rev_step", 0, 0, 1, 0);

        // Fault at Pos=5 is sticky and freezes Pos.
        do_reset();
        for (int c = 0; c < 21; c++) step(1, 0);
        check_out("flt_pre", 5, 0, 0, 0);
        step(1, 1);
        check_out("flt_set", 5, 0, 0, 1);
        for (int c = 0; c < 20; c++) step(1'($urandom), 1'($urandom));
        check_out("flt_hold", 5, 0, 0, 1);

        // Mid-move asynchronous reset at Pos=3, partial count 2.
        do_reset();
        for (int c = 0; c < 15; c++) step(1, 0);
        check_out("mid_pre", 3, 0, 0, 0);
        RST = 1'b0;
        #2;
        check_out("mid_async", 0, 0, 1, 0);
        #1;
        RST = 1'b1;
        model_reset();
        step(1, 0);
        for (int c = 0; c < 3; c++) step(1, 0);
        check_out("mid_early", 0, 0, 1, 0);
        step(1, 0);
        check_out("mid_step", 1, 0, 0, 0);

        // Divide-by-one instance steps every cycle in motion.
        do_reset();
        up1 = 1'b1;
        step(0, 0);
        chk("td1.enter", int'(pos1), 0);
        step(0, 0);
        chk("td1.first", int'(pos1), 1);
        for (int c = 0; c < 4; c++) step(0, 0);
        chk("td1.sat", int'(pos1), 3);
        chk("td1.up_max", int'(umax1), 1);
        up1 = 1'b0;

        // Randomized command runs against the model.
        do_reset();
        hold = 0;
        cu = 0;
        cd = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 399) do_reset();
            if (hold == 0) begin
                int r;
                r = $urandom_range(0, 99);
                cu = (r < 45) || (r >= 98);
                cd = (r >= 45 && r < 85) || (r >= 98);
                hold = $urandom_range(1, 14);
            end
            hold--;
            step(cu, cd);
            check_out("rand", m_pos, m_pos == PM, m_pos == 0, m_flt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
